// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO write-side arbiter: FSM states,
// default sizing constants and the round-robin pick helper.
package fifo_pkg;

  localparam int unsigned FIFO_DW       = 8;
  localparam int unsigned ARB_MAX_BURST = 16;
  // Widest requester set the pick helper handles.
  localparam int unsigned RR_MAX_N      = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  // First set bit of valid at or above ptr, wrapping modulo n.
  // Returns 0 when nothing is valid. ptr must be below n, so the
  // wrapped position is at most 2n-2 and a single subtract folds it back.
  function automatic logic [2:0] rr_pick(input logic [7:0]  valid,
                                         input logic [2:0]  ptr,
                                         input int unsigned n = RR_MAX_N);
    logic [2:0]  idx;
    logic        found;
    int unsigned pos;
    idx   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < RR_MAX_N; k++) begin
      if (k < n) begin
        pos = int'(ptr) + k;
        if (pos >= n) pos = pos - n;
        if (!found && valid[pos[2:0]]) begin
          idx   = pos[2:0];
          found = 1'b1;
        end
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_prio_enc.sv
// Combinational round-robin priority encoder: picks the first valid
// requester starting at ptr and wrapping around.
module rr_prio_enc
  import fifo_pkg::*;
#(
  parameter  int unsigned N_REQ = 4,
  localparam int unsigned IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] valid,
  input  logic [IW-1:0]    ptr,
  output logic [IW-1:0]    idx,
  output logic             any
);

  // Search from ptr upward; any flags that idx is meaningful.
  always_comb begin
    idx = IW'(rr_pick(8'(valid), 3'(ptr), N_REQ));
    any = |valid;
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Write-side arbiter sharing one FIFO write port between N_REQ producers.
// Round-robin grants, bursts bounded by MAX_BURST, never writes while the
// FIFO reports full. Data path is purely combinational from the grant.
module fifo_wr_arbiter
  import fifo_pkg::*;
#(
  parameter  int unsigned N_REQ     = 4,
  parameter  int unsigned DW        = FIFO_DW,
  parameter  int unsigned MAX_BURST = ARB_MAX_BURST,
  localparam int unsigned GW        = $clog2(N_REQ),
  localparam int unsigned BW        = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1
) (
  input  logic                clk_w,
  input  logic                reset_n,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [N_REQ*DW-1:0] req_data,
  output logic [N_REQ-1:0]    req_ready,
  input  logic                overflow,
  output logic [DW-1:0]       data_w,
  output logic                wr_en,
  output logic [GW-1:0]       gnt_id,
  output logic                busy
);

  arb_state_e    state_q, state_d;
  logic [GW-1:0] gnt_q, gnt_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic [GW-1:0] rr_q, rr_d;

  logic [GW-1:0] pick_idx;
  logic          pick_any;
  logic          lane_valid;
  logic [DW-1:0] lane_data;
  logic [GW-1:0] rr_next;
  logic          last_beat;

  rr_prio_enc #(
    .N_REQ (N_REQ)
  ) u_pick (
    .valid (req_valid),
    .ptr   (rr_q),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // Select the granted lane's valid and data, plus burst bookkeeping.
  always_comb begin
    lane_valid = 1'b0;
    lane_data  = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (gnt_q == GW'(i)) begin
        lane_valid = req_valid[i];
        lane_data  = req_data[i*DW +: DW];
      end
    end
    rr_next   = (gnt_q == GW'(N_REQ - 1)) ? '0 : gnt_q + 1'b1;
    last_beat = (bcnt_q == BW'(MAX_BURST - 1));
  end

  // Next-state logic and write-port outputs.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    bcnt_d    = bcnt_q;
    rr_d      = rr_q;
    wr_en     = 1'b0;
    req_ready = '0;
    data_w    = '0;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          gnt_d   = pick_idx;
          bcnt_d  = '0;
          state_d = BURST;
        end
      end
      BURST: begin
        // Overflow only stalls; release or the burst limit ends the grant.
        wr_en = lane_valid & ~overflow;
        if (wr_en) begin
          data_w = lane_data;
          bcnt_d = bcnt_q + 1'b1;
          for (int unsigned i = 0; i < N_REQ; i++) begin
            req_ready[i] = (gnt_q == GW'(i));
          end
        end
        if (!lane_valid || (wr_en && last_beat)) begin
          state_d = IDLE;
          rr_d    = rr_next;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_w) begin
    if (!reset_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      bcnt_q  <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      bcnt_q  <= bcnt_d;
      rr_q    <= rr_d;
    end
  end

  assign gnt_id = gnt_q;
  assign busy   = (state_q == BURST);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (N_REQ=4, DW=8, MAX_BURST=4).
// Stimulus pushes expected writes tagged with their cycle; a negedge
// monitor pops and compares whenever the DUT writes.
module tb_fifo_wr_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   valid;
  logic [DW-1:0]  ld [N];
  logic [N*DW-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           ovf;
  logic [DW-1:0]  data_w;
  logic           wr_en;
  logic [1:0]     gnt_id;
  logic           busy;

  typedef struct {
    int         cyc;
    int         lane;
    logic [7:0] data;
  } exp_t;

  exp_t q[$];
  int   cyc    = 0;
  int   tests  = 0;
  int   fails  = 0;
  int   adv    = -1;
  bit   mon_en = 1'b0;

  assign req_data = {ld[3], ld[2], ld[1], ld[0]};

  fifo_wr_arbiter #(
    .N_REQ     (4),
    .DW        (8),
    .MAX_BURST (4)
  ) dut (
    .clk_w     (clk),
    .reset_n   (rst_n),
    .req_valid (valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .overflow  (ovf),
    .data_w    (data_w),
    .wr_en     (wr_en),
    .gnt_id    (gnt_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Advance one cycle; the lane written in the previous cycle moves to its next word.
  task automatic step();
    @(posedge clk);
    #1;
    if (adv >= 0) ld[adv] = ld[adv] + 8'h01;
    adv = -1;
  endtask

  task automatic wr(input int lane, input logic [7:0] data);
    exp_t e;
    e.cyc  = cyc;
    e.lane = lane;
    e.data = data;
    q.push_back(e);
    adv = lane;
  endtask

  // Monitor: every write must match the head of the queue in cycle, lane and data.
  always @(negedge clk) begin
    if (mon_en) begin
      while (q.size() > 0 && q[0].cyc < cyc) begin
        tests++;
        fails++;
        $display("FAIL missed_write: got none expected lane %0d data %0h at cycle %0d",
                 q[0].lane, q[0].data, q[0].cyc);
        void'(q.pop_front());
      end
      if (wr_en) begin
        if (q.size() == 0 || q[0].cyc != cyc) begin
          tests++;
          fails++;
          $display("FAIL unexpected_write: got data %0h gnt %0d expected no write (cycle %0d)",
                   data_w, gnt_id, cyc);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("wr_data",  32'(data_w),    32'(e.data));
          check("wr_gnt",   32'(gnt_id),    32'(e.lane));
          check("wr_ready", 32'(req_ready), 32'(4'b0001 << e.lane));
        end
      end else begin
        check("idle_ready", 32'(req_ready), 32'h0);
        check("idle_data",  32'(data_w),    32'h0);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    valid = 4'hF;
    ovf   = 1'b0;
    for (int i = 0; i < 4; i++) ld[i] = 8'hEE;

    // Reset with every lane requesting: outputs must still be quiet.
    step();
    step();
    check("rst_wr_en", 32'(wr_en),     32'h0);
    check("rst_ready", 32'(req_ready), 32'h0);
    check("rst_data",  32'(data_w),    32'h0);
    check("rst_busy",  32'(busy),      32'h0);
    check("rst_gnt",   32'(gnt_id),    32'h0);
    rst_n  = 1'b1;
    valid  = '0;
    mon_en = 1'b1;
    step();

    // Single requester on lane 2: 0x11..0x14 hits the limit, idle, then 0x15.
    valid = 4'b0100;
    ld[2] = 8'h11;
    check("t1_idle_busy", 32'(busy), 32'h0);
    for (int w = 0; w < 4; w++) begin
      step();
      wr(2, 8'(8'h11 + w));
      if (w == 0) begin
        check("t1_busy", 32'(busy),   32'h1);
        check("t1_gnt",  32'(gnt_id), 32'h2);
      end
    end
    step();
    check("t1_rearb_busy", 32'(busy), 32'h0);
    step();
    wr(2, 8'h15);
    step();
    valid = '0;
    step();
    check("t1_end_busy", 32'(busy),   32'h0);
    check("t1_end_gnt",  32'(gnt_id), 32'h2);

    // Round-robin wrap: pointer is 3, lanes 0 and 3 valid -> lane 3 first.
    valid = 4'b1001;
    ld[0] = 8'hA0;
    ld[3] = 8'hD0;
    step();
    wr(3, 8'hD0);
    step();
    valid = 4'b0001;
    step();
    check("t4_gap_busy", 32'(busy),   32'h0);
    check("t4_gap_gnt",  32'(gnt_id), 32'h3);
    step();
    wr(0, 8'hA0);
    step();
    valid = '0;
    step();

    // Reset in the middle of a lane-1 burst.
    valid = 4'b0010;
    ld[1] = 8'h51;
    step();
    wr(1, 8'h51);
    step();
    wr(1, 8'h52);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    valid = 4'b0011;
    ld[0] = 8'h01;
    check("t5_wr_en", 32'(wr_en),     32'h0);
    check("t5_ready", 32'(req_ready), 32'h0);
    check("t5_data",  32'(data_w),    32'h0);
    check("t5_busy",  32'(busy),      32'h0);
    check("t5_gnt",   32'(gnt_id),    32'h0);

    // Burst limit: 4x lane0, idle, 4x lane1, idle, 4x lane0.
    for (int b = 0; b < 3; b++) begin
      int ln;
      logic [7:0] base;
      ln   = (b == 1) ? 1 : 0;
      base = (b == 0) ? 8'h01 : (b == 1) ? 8'h53 : 8'h05;
      for (int w = 0; w < 4; w++) begin
        step();
        wr(ln, 8'(base + w));
      end
      step();
      check("t2_gap_busy", 32'(busy), 32'h0);
      if (b == 2) begin
        valid = 4'b0010;
        ld[1] = 8'h31;
      end
    end

    // Overflow stall after the 2nd word: grant and counter held for 3 cycles.
    step();
    wr(1, 8'h31);
    step();
    wr(1, 8'h32);
    step();
    ovf = 1'b1;
    check("t3_stall_busy", 32'(busy),   32'h1);
    check("t3_stall_gnt",  32'(gnt_id), 32'h1);
    step();
    step();
    check("t3_stall_wr", 32'(wr_en), 32'h0);
    step();
    ovf = 1'b0;
    wr(1, 8'h33);
    step();
    wr(1, 8'h34);
    step();
    check("t3_limit_busy", 32'(busy), 32'h0);
    step();
    wr(1, 8'h35);

    // Release while overflow is high: exits with no write, lane 3 next.
    step();
    ovf   = 1'b1;
    valid = 4'b1000;
    ld[3] = 8'h3C;
    check("t6_rel_busy", 32'(busy),   32'h1);
    check("t6_rel_gnt",  32'(gnt_id), 32'h1);
    step();
    ovf = 1'b0;
    check("t6_idle_busy", 32'(busy), 32'h0);
    step();
    wr(3, 8'h3C);
    check("t6_gnt", 32'(gnt_id), 32'h3);
    step();
    valid = '0;
    step();
    step();
    step();

    check("queue_drained", 32'(q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Write-side arbiter for the async FIFO in the `clk_w` domain. It shares the single 8-bit FIFO write port (`data_w`/`wr_en`) between `N_REQ` producers, using round-robin grants with bounded bursts. It honours the FIFO's `overflow` (full) flag so that no write is ever issued into a full FIFO. It replaces the single-producer write front end when several sources feed one FIFO.

## Interface
- `N_REQ`, default 4: number of requesters, range 2..8.
- `DW`, default 8: data width, matching the FIFO write width.
- `MAX_BURST`, default 16: maximum writes per grant, range 1..256.
- `clk_w` in 1: write-domain clock.
- `reset_n` in 1: reset, synchronous and active-low.
- `req_valid` in `N_REQ`: requester i has a word on its lane.
- `req_data` in `N_REQ*DW`: lane i occupies bits `[i*DW +: DW]`.
- `req_ready` out `N_REQ`: the word on lane i is taken this cycle. One-hot or zero.
- `overflow` in 1: FIFO full, write side. A write in the same cycle is forbidden.
- `data_w` out `DW`: FIFO write data.
- `wr_en` out 1: FIFO write strobe.
- `gnt_id` out `$clog2(N_REQ)`: index of the current or last grantee.
- `busy` out 1: the FSM is in BURST.

## Operation
- FSM states are IDLE and BURST, held in a registered `state`, `gnt_id`, burst counter `bcnt` and round-robin pointer `rr_ptr`.
- IDLE:
  - If any `req_valid` is set, pick the first set bit searching from `rr_ptr` upward and wrap modulo `N_REQ`.
  - Register it into `gnt_id`, clear `bcnt` and go to BURST.
  - No write is issued in IDLE.
- BURST:
  - `wr_en = req_valid[gnt_id] & ~overflow & (state==BURST)`.
  - `req_ready[gnt_id] = wr_en`; all other `req_ready` bits are 0.
  - `data_w = wr_en ? req_data[gnt_id] : 0`.
  - Each write increments `bcnt`.
- Leave BURST (to IDLE, with `rr_ptr <= (gnt_id+1) mod N_REQ`) when either:
  - a write occurs with `bcnt == MAX_BURST-1`, or
  - `req_valid[gnt_id] == 0` (the requester releases).
- Release while `overflow` is 1 still exits. Overflow alone never ends a burst.
- Overflow stall: in BURST with `overflow=1`:
  - no write, no `req_ready`, `bcnt` holds;
  - the grant is held, so the requester's data must stay stable (valid/ready rule: a word, once valid, is held until ready).
- Non-grantees are never acknowledged. Their valid may rise or fall freely.
- Fairness: after grantee i, i is the lowest priority in the next arbitration. Every continuously-valid requester is served within `N_REQ-1` bursts.
- Reset: while `reset_n=0` at a `clk_w` edge:
  - `state<=IDLE`, `gnt_id<=0`, `bcnt<=0`, `rr_ptr<=0`.
  - Outputs are then `wr_en=0`, `req_ready=0`, `data_w=0`, `busy=0`, `gnt_id=0`.
- Reset mid-burst aborts the grant immediately. No partial-word state remains.
- `bcnt` width is `$clog2(MAX_BURST)` (minimum 1). The compare is exact, with no wrap.

## Timing
- Arbitration latency: 1 cycle. A request seen in IDLE in cycle t gives the first possible write in t+1.
- Turnaround: after a burst ends in cycle t (IDLE at t+1), the next grant is decided in t+1 and its write comes in t+2. There is one idle cycle between bursts.
- `wr_en`, `req_ready` and `data_w` are combinational from registered state plus `req_valid`/`req_data`/`overflow`. There is no added pipeline latency and no register on the data path.
- Peak throughput is `MAX_BURST` words per `MAX_BURST+1` cycles when several requesters contend. A single continuous requester also re-arbitrates after each burst.
- Simultaneous events:
  - burst-limit write plus a new request from another lane: the limit exit is taken and the other lane is arbitrated next cycle.
  - `overflow` rising in the same cycle as the final write: no write; the counter holds and the burst continues.

## Structure
- Shared package `fifo_pkg`:
  - FSM state enum (IDLE, BURST);
  - helper function `rr_pick(valid, ptr)` returning an index;
  - default constants `FIFO_DW=8`, `ARB_MAX_BURST=16`.
- One natural sub-module, `rr_prio_enc`: combinational round-robin priority encoder (inputs `valid`, `ptr`; outputs `idx`, `any`). It is instantiated once.
- Everything else (FSM, counter, lane mux) lives in the top level.

## Test plan
- Single requester: lane 2 streams 5 words 0x11..0x15, then drops valid.
  - Expect `wr_en` on 5 consecutive cycles starting 1 cycle after valid rises, `data_w` matching, `gnt_id=2`, then IDLE.
- Burst limit: `MAX_BURST=4`, lanes 0 and 1 continuously valid with incrementing data.
  - Expect writes ordered 4×lane0, idle cycle, 4×lane1, idle cycle, 4×lane0.
- Overflow stall: assert `overflow` for 3 cycles after the 2nd word of a grant.
  - Expect `wr_en=0` and `req_ready=0` for those 3 cycles, the same grant held, `bcnt` unchanged, and the 3rd word written on the first cycle `overflow=0`.
- Round-robin wrap: `rr_ptr=3` (after a lane-2 grant), lanes 0 and 3 valid.
  - Expect lane 3 granted first, then lane 0.
- Reset mid-burst: drop `reset_n` for 1 cycle during a lane-1 burst.
  - Expect all outputs at reset values the next cycle and `rr_ptr=0`, so lane 0 wins if lanes 0 and 1 are both valid afterwards.
- Release during overflow: the grantee drops valid while `overflow=1`.
  - Expect no write, return to IDLE, and the next lane granted.
